// File: rtl/seg7_pkg.sv
// Shared types and constants for the 8-digit hexadecimal 7-segment scanner.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 8;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'b0000000;

  // Active-high {g,f,e,d,c,b,a} patterns for 0..F
  localparam seg7_t SEG_TABLE [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  // Bit i set when nibbles i..7 are all zero; digit 0 is never blanked.
  function automatic logic [7:0] lead_zero_mask(input logic [31:0] word);
    logic [7:0] mask;
    logic       all_zero;
    mask     = '0;
    all_zero = 1'b1;
    for (int unsigned i = NUM_DIGITS - 1; i > 0; i--) begin
      all_zero = all_zero && (word[4*i +: 4] == 4'h0);
      mask[i]  = all_zero;
    end
    return mask;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-high 7-segment pattern.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output seg7_t      seg
);

  always_comb begin
    seg = SEG_TABLE[nibble];
  end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed 8-digit hex 7-segment scanner with frame-synchronous
// shadow loading, leading-zero blanking and an anti-ghosting guard interval.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter logic [15:0] DIV_MAX    = 16'd49999,
  parameter int unsigned GUARD      = 4,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value_in,
  input  logic        freeze,
  input  logic        blank_en,
  input  logic [7:0]  dp_in,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam logic [15:0] GUARD_CNT = 16'(GUARD);
  localparam logic [7:0]  AN_POL    = {8{ACTIVE_LOW}};
  localparam seg7_t       SEG_POL   = {7{ACTIVE_LOW}};

  logic [15:0] cnt;
  logic [2:0]  idx;
  logic [31:0] shadow;
  logic [7:0]  blank_mask;

  logic        tick;
  logic        frame_end;
  logic [3:0]  cur_nibble;
  seg7_t       cur_seg;
  logic [7:0]  an_nxt;
  seg7_t       seg_nxt;
  logic        dp_nxt;

  always_comb begin
    tick       = (cnt == DIV_MAX);
    frame_end  = tick && (idx == 3'd7);
    cur_nibble = shadow[{idx, 2'b00} +: 4];
  end

  hex_to_seg7 u_hex (
    .nibble (cur_nibble),
    .seg    (cur_seg)
  );

  // Active-high view of the next outputs; polarity is applied at the register.
  always_comb begin
    an_nxt  = '0;
    seg_nxt = SEG_BLANK;
    dp_nxt  = 1'b0;
    if (cnt >= GUARD_CNT && !blank_mask[idx]) begin
      an_nxt[idx] = 1'b1;
      seg_nxt     = cur_seg;
      dp_nxt      = dp_in[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      shadow     <= '0;
      blank_mask <= '0;
      frame_tick <= 1'b0;
      an         <= AN_POL;
      seg        <= SEG_BLANK ^ SEG_POL;
      dp         <= ACTIVE_LOW;
    end else begin
      cnt        <= tick ? '0 : cnt + 16'd1;
      if (tick) begin
        idx <= idx + 3'd1;
      end
      frame_tick <= frame_end;
      if (frame_end && !freeze) begin
        shadow     <= value_in;
        blank_mask <= blank_en ? lead_zero_mask(value_in) : '0;
      end
      an  <= an_nxt ^ AN_POL;
      seg <= seg_nxt ^ SEG_POL;
      dp  <= dp_nxt ^ ACTIVE_LOW;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Randomized self-checking bench for seg7_scan against a cycle-count based model.
module tb_seg7_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] value_in;
  logic        freeze;
  logic        blank_en;
  logic [7:0]  dp_in;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  seg7_scan #(
    .DIV_MAX    (16'd7),
    .GUARD      (2),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .value_in   (value_in),
    .freeze     (freeze),
    .blank_en   (blank_en),
    .dp_in      (dp_in),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: digit period 8 cycles, frame 64 cycles, first 2 cycles of a digit dark.
  logic [6:0] hex_seg [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  int unsigned m_t = 0;
  logic [31:0] m_shadow = '0;
  int unsigned m_top = 7;
  bit          model_valid = 1'b0;
  logic [7:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic        exp_ft;

  function automatic int unsigned top_nonzero(input logic [31:0] v);
    int unsigned t = 0;
    for (int unsigned i = 0; i < 8; i++)
      if (((v >> (4 * i)) & 32'hF) != 0) t = i;
    return t;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      exp_an = 8'hFF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_ft = 1'b0;
      m_t = 0; m_shadow = '0; m_top = 7; model_valid = 1'b1;
    end else begin
      int unsigned phase, dig;
      logic [31:0] nib;
      bit          lit;
      phase = m_t % 8;
      dig   = (m_t / 8) % 8;
      lit   = (phase >= 2) && (dig <= m_top);
      nib   = (m_shadow >> (4 * dig)) & 32'hF;
      exp_an  = lit ? ~(8'd1 << dig) : 8'hFF;
      exp_seg = lit ? ~hex_seg[nib[3:0]] : 7'h7F;
      exp_dp  = lit ? ~dp_in[dig] : 1'b1;
      exp_ft  = ((m_t % 64) == 63);
      if (exp_ft && !freeze) begin
        m_shadow = value_in;
        m_top    = blank_en ? top_nonzero(value_in) : 7;
      end
      m_t++;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      chk("an", {24'd0, an}, {24'd0, exp_an});
      chk("seg", {25'd0, seg}, {25'd0, exp_seg});
      chk("dp", {31'd0, dp}, {31'd0, exp_dp});
      chk("frame_tick", {31'd0, frame_tick}, {31'd0, exp_ft});
      chk("onehot0_an", {31'd0, $onehot0(~an)}, 32'd1);
    end
  end

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_phase(input int unsigned target);
    int unsigned guard_cnt = 0;
    while ((m_t % 64) != target && guard_cnt < 200) begin
      step(1);
      guard_cnt++;
    end
    chk("wait_phase_bound", {31'd0, guard_cnt < 200}, 32'd1);
  endtask

  initial begin
    bit          bad_an, seen_a, seen_0, dp_bad, seen_dp;
    int unsigned ticks;

    rst = 1'b1; value_in = '0; freeze = 1'b0; blank_en = 1'b0; dp_in = '0;
    step(2);
    rst = 1'b0;
    value_in = 32'h1234_5678;

    // Pre-frame: shadow is zero, digit 0 shows "0"
    step(3);
    chk("lit_pre_an", {24'd0, an}, 32'h0000_00FE);
    chk("lit_pre_seg", {25'd0, seg}, {25'd0, 7'b1000000});
    step(61);
    chk("lit_frame_tick", {31'd0, frame_tick}, 32'd1);
    step(3);
    chk("lit_d0_an", {24'd0, an}, 32'h0000_00FE);
    chk("lit_d0_seg", {25'd0, seg}, {25'd0, 7'b0000000});
    step(56);
    chk("lit_d7_an", {24'd0, an}, 32'h0000_007F);
    chk("lit_d7_seg", {25'd0, seg}, {25'd0, 7'b1111001});

    // Leading-zero blanking
    value_in = 32'h0000_00A0; blank_en = 1'b1;
    step(66);
    bad_an = 0; seen_a = 0; seen_0 = 0;
    repeat (128) begin
      step(1);
      if (an != 8'hFF && an != 8'hFE && an != 8'hFD) bad_an = 1;
      if (an == 8'hFD && seg == 7'b0001000) seen_a = 1;
      if (an == 8'hFE && seg == 7'b1000000) seen_0 = 1;
    end
    chk("blank_only_d1_d0", {31'd0, bad_an}, 32'd0);
    chk("blank_d1_shows_A", {31'd0, seen_a}, 32'd1);
    chk("blank_d0_shows_0", {31'd0, seen_0}, 32'd1);

    value_in = '0;
    step(66);
    bad_an = 0; seen_0 = 0;
    repeat (128) begin
      step(1);
      if (an != 8'hFF && an != 8'hFE) bad_an = 1;
      if (an == 8'hFE && seg == 7'b1000000) seen_0 = 1;
    end
    chk("zero_only_d0", {31'd0, bad_an}, 32'd0);
    chk("zero_d0_shows_0", {31'd0, seen_0}, 32'd1);

    // Freeze across three frames with value_in churning
    blank_en = 1'b0; freeze = 1'b1;
    ticks = 0;
    repeat (192) begin
      value_in = $urandom;
      step(1);
      if (frame_tick) ticks++;
    end
    chk("freeze_tick_count", ticks, 32'd3);
    freeze = 1'b0; value_in = 32'hCAFE_0123;
    step(130);

    // Mid-frame change at idx=3
    wait_phase(24);
    value_in = $urandom;
    step(130);

    // Reset mid-frame at idx=5, cnt=3
    dp_in = '0;
    wait_phase(43);
    rst = 1'b1;
    step(1);
    chk("rst_an", {24'd0, an}, 32'h0000_00FF);
    chk("rst_seg", {25'd0, seg}, 32'h0000_007F);
    chk("rst_dp", {31'd0, dp}, 32'd1);
    chk("rst_frame_tick", {31'd0, frame_tick}, 32'd0);
    rst = 1'b0;
    step(3);
    chk("rst_restart_an", {24'd0, an}, 32'h0000_00FE);
    chk("rst_restart_seg", {25'd0, seg}, {25'd0, 7'b1000000});

    // Decimal point on digit 2 only
    dp_in = 8'b0000_0100; value_in = $urandom;
    dp_bad = 0; seen_dp = 0;
    repeat (130) begin
      step(1);
      if ((dp == 1'b0) != (an == 8'hFB)) dp_bad = 1;
      if (dp == 1'b0) seen_dp = 1;
    end
    chk("dp_only_digit2", {31'd0, dp_bad}, 32'd0);
    chk("dp_seen_lit", {31'd0, seen_dp}, 32'd1);

    // Randomized soak
    for (int unsigned k = 0; k < 40; k++) begin
      value_in = ($urandom_range(0, 3) == 0) ? ($urandom >> (4 * $urandom_range(0, 7))) : $urandom;
      blank_en = $urandom_range(0, 1) == 1;
      freeze   = $urandom_range(0, 3) == 0;
      dp_in    = 8'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1;
        step(1);
        rst = 1'b0;
      end
      step($urandom_range(1, 100));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
